// File: rtl/mips_wb_pkg.sv
// Shared types and constants for the MEM/WB writeback stage.
package mips_wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_REG_AW = 5;

   localparam logic [1:0] LD_BYTE = 2'b00;
   localparam logic [1:0] LD_HALF = 2'b01;
   localparam logic [1:0] LD_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      COMMIT   = 2'b01,
      WAIT_MEM = 2'b10,
      DRAIN    = 2'b11
   } wb_state_t;

   // Load attributes held while the data-memory read is outstanding.
   typedef struct packed {
      logic [1:0] size;
      logic [1:0] off;
      logic       uns;
   } ld_fmt_t;

endpackage

// File: rtl/load_formatter.sv
// Combinational sub-word load lane select and sign/zero extension.
// Compiled only when WB_SUBWORD_EN is defined.
`ifdef WB_SUBWORD_EN
module load_formatter
   import mips_wb_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W
) (
   input  logic [DATA_W-1:0] rdata_i,
   input  logic [1:0]        off_i,
   input  logic [1:0]        size_i,
   input  logic              unsigned_i,
   output logic [DATA_W-1:0] data_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   assign byte_lane = rdata_i[{off_i, 3'b000} +: 8];
   assign half_lane = rdata_i[{off_i[1], 4'b0000} +: 16];

   always_comb begin
      // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
      data_o = rdata_i;
      case (size_i)
         LD_BYTE: data_o = {{(DATA_W-8){byte_lane[7] & ~unsigned_i}}, byte_lane};
         LD_HALF: data_o = {{(DATA_W-16){half_lane[15] & ~unsigned_i}}, half_lane};
         default: data_o = rdata_i;
      endcase
   end

endmodule
`endif

// File: rtl/writeback_stage.sv
// MEM/WB stage driving the register-bank write port from the ALU result or returned load data.
// Define WB_SUBWORD_EN to format byte/half loads; otherwise loads write mem_rdata unchanged.
module writeback_stage
   import mips_wb_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int REG_AW = WB_REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_regwrite,
   input  logic              in_memtoreg,
   input  logic [REG_AW-1:0] in_waddr,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [1:0]        in_ld_size,
   input  logic              in_ld_unsigned,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              flush,
   output logic [DATA_W-1:0] wrData,
   output logic [REG_AW-1:0] wAddr,
   output logic              regWriteFlag,
   output logic              busy,
   output logic              err_unexp
);

   wb_state_t         state_q, state_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [REG_AW-1:0] waddr_q, waddr_d;
   logic              wen_q, wen_d;
   logic              err_q, err_d;
   logic [REG_AW-1:0] ld_waddr_q, ld_waddr_d;
   logic              ld_we_q, ld_we_d;
   logic [DATA_W-1:0] ld_data;
   logic              can_accept, accept;

`ifdef WB_SUBWORD_EN
   ld_fmt_t ld_fmt_q, ld_fmt_d;

   load_formatter #(.DATA_W(DATA_W)) u_load_formatter (
      .rdata_i    (mem_rdata),
      .off_i      (ld_fmt_q.off),
      .size_i     (ld_fmt_q.size),
      .unsigned_i (ld_fmt_q.uns),
      .data_o     (ld_data)
   );
`else
   logic unused_ld_cfg;

   assign ld_data       = mem_rdata;
   assign unused_ld_cfg = ^{in_ld_size, in_ld_unsigned};
`endif

   assign can_accept   = (state_q == IDLE) || (state_q == COMMIT);
   assign in_ready     = !rst && can_accept;
   assign accept       = in_valid && in_ready && !flush;
   assign wrData       = wdata_q;
   assign wAddr        = waddr_q;
   assign regWriteFlag = wen_q;
   assign busy         = (state_q != IDLE);
   assign err_unexp    = err_q;

   always_comb begin
      state_d    = state_q;
      wdata_d    = wdata_q;
      waddr_d    = waddr_q;
      wen_d      = 1'b0;
      err_d      = err_q;
      ld_waddr_d = ld_waddr_q;
      ld_we_d    = ld_we_q;
`ifdef WB_SUBWORD_EN
      ld_fmt_d   = ld_fmt_q;
`endif

      if (mem_rvalid && can_accept) err_d = 1'b1;

      case (state_q)
         IDLE, COMMIT: begin
            state_d = IDLE;
            if (accept && in_memtoreg) begin
               state_d    = WAIT_MEM;
               ld_waddr_d = in_waddr;
               ld_we_d    = in_regwrite;
`ifdef WB_SUBWORD_EN
               ld_fmt_d   = '{size: in_ld_size, off: in_alu_result[1:0], uns: in_ld_unsigned};
`endif
            end else if (accept) begin
               state_d = COMMIT;
               wdata_d = in_alu_result;
               waddr_d = in_waddr;
               wen_d   = in_regwrite && (in_waddr != '0);
            end
         end
         WAIT_MEM: begin
            // A flushed load still owes a response; DRAIN swallows it unless it lands now.
            if (flush) begin
               state_d = mem_rvalid ? IDLE : DRAIN;
            end else if (mem_rvalid) begin
               state_d = COMMIT;
               wdata_d = ld_data;
               waddr_d = ld_waddr_q;
               wen_d   = ld_we_q && (ld_waddr_q != '0);
            end
         end
         DRAIN: begin
            if (mem_rvalid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q    <= IDLE;
         wdata_q    <= '0;
         waddr_q    <= '0;
         wen_q      <= 1'b0;
         err_q      <= 1'b0;
         ld_waddr_q <= '0;
         ld_we_q    <= 1'b0;
`ifdef WB_SUBWORD_EN
         ld_fmt_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         wdata_q    <= wdata_d;
         waddr_q    <= waddr_d;
         wen_q      <= wen_d;
         err_q      <= err_d;
         ld_waddr_q <= ld_waddr_d;
         ld_we_q    <= ld_we_d;
`ifdef WB_SUBWORD_EN
         ld_fmt_q   <= ld_fmt_d;
`endif
      end
   end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

MEM/WB pipeline stage that sits directly upstream of the register bank and drives its write port (`wrData`, `wAddr`, `regWriteFlag`). It accepts one retiring instruction per cycle from the memory stage and selects between the ALU result and returned load data. For loads, it waits on the data-memory read handshake, and it formats sub-word loads. It also suppresses writes to `$zero` and handles pipeline flushes, including flushes that arrive while a load is still outstanding.

## Interface
- `DATA_W`, 32, datapath width
- `REG_AW`, 5, register address width
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  upstream instruction valid
- `in_ready`  out  1  stage can accept this cycle
- `in_regwrite`  in  1  instruction writes a register
- `in_memtoreg`  in  1  result comes from memory (load)
- `in_waddr`  in  REG_AW  destination register
- `in_alu_result`  in  DATA_W  ALU result / effective address
- `in_ld_size`  in  2  00 byte, 01 half, 10 word
- `in_ld_unsigned`  in  1  zero-extend sub-word load
- `mem_rvalid`  in  1  load data valid (one-cycle pulse)
- `mem_rdata`  in  DATA_W  load data, little-endian word
- `flush`  in  1  kill all uncommitted work
- `wrData`  out  DATA_W  register-bank write data
- `wAddr`  out  REG_AW  register-bank write address
- `regWriteFlag`  out  1  register-bank write enable (single-cycle pulse)
- `busy`  out  1  state is not IDLE
- `err_unexp`  out  1  sticky: `mem_rvalid` received with no load outstanding

## Operation
- States:
  - IDLE: nothing pending.
  - COMMIT: write outputs are driven this cycle.
  - WAIT_MEM: a load is awaiting `mem_rvalid`.
  - DRAIN: a flushed load is awaiting its `mem_rvalid`, which is discarded.
- `in_ready` = !rst && (state == IDLE || state == COMMIT).
- Accept is `in_valid && in_ready && !flush`.
  - Non-load accepted: the next state is COMMIT. The next cycle drives `wrData` = `in_alu_result`, `wAddr` = `in_waddr`, and `regWriteFlag` = `in_regwrite && in_waddr != 0`.
  - Load accepted: capture `in_waddr`, `in_regwrite`, size/sign and `in_alu_result[1:0]`, then go to WAIT_MEM.
- WAIT_MEM with `mem_rvalid`: the next state is COMMIT with formatted load data. The write enable follows the same `$zero` rule.
- COMMIT with no accept: go to IDLE and drop `regWriteFlag`. COMMIT with accept: follow the accept rules, so throughput is one per cycle.
- Flush:
  - In IDLE or COMMIT: blocks the accept and the next state is IDLE. The current COMMIT outputs are already committed and are not cancelled.
  - In WAIT_MEM: the next state is DRAIN, or IDLE if `mem_rvalid` is high in the same cycle, with no write in either case.
  - In DRAIN: no effect.
- DRAIN with `mem_rvalid`: go to IDLE with no write.
- `mem_rvalid` in IDLE or COMMIT sets `err_unexp`; the data is ignored. Only reset clears `err_unexp`.
- Load formatting uses byte offset `off` = captured addr[1:0]:
  - Byte: lane `off`.
  - Half: lane `off[1]`.
  - Sign- or zero-extend per `in_ld_unsigned`.
  - Word: unchanged; `off` is ignored.

## Timing
- Reset (async assert, sync release by design): state IDLE; `wrData`=0, `wAddr`=0, `regWriteFlag`=0, `busy`=0, `err_unexp`=0, `in_ready`=0 while `rst` is high.
- All write-port outputs are registered. Latency is:
  - ALU ops: 1 cycle from accept to `regWriteFlag`.
  - Loads: 1 cycle after the `mem_rvalid` cycle.
- `regWriteFlag` is high for exactly one cycle per committed write. Back-to-back commits keep it high on consecutive cycles with new `wAddr`/`wrData`.
- `flush` and `in_valid` in the same cycle: flush wins.
- Reset asserted mid-load: the outstanding load is abandoned with no DRAIN. The memory side is reset by the same `rst`.

## Configuration
- `WB_SUBWORD_EN` defined: byte and half loads are formatted as above.
- `WB_SUBWORD_EN` undefined:
  - `in_ld_size` and `in_ld_unsigned` are ignored and every load writes `mem_rdata` unchanged.
  - The formatter is not instantiated.

## Structure
- Package `mips_wb_pkg`:
  - State enum `wb_state_t` (IDLE, COMMIT, WAIT_MEM, DRAIN).
  - Load-size constants `LD_BYTE`/`LD_HALF`/`LD_WORD`.
  - `DATA_W`/`REG_AW` defaults.
- One sub-module, `load_formatter`: purely combinational lane select and extension (`rdata`, `off`, `size`, `unsigned` -> `data`). It is compiled only under `WB_SUBWORD_EN`.

## Test plan
- ALU commit to `$zero`: accept ALU op waddr=9, result 0x1234_5678, then waddr=0 next cycle -> cycle+1 write r9=0x12345678; cycle+2 `regWriteFlag`=0.
- Signed byte load: load waddr=3, addr[1:0]=2, signed byte; `mem_rvalid` 4 cycles later with 0x0080_0000 -> `in_ready`=0 while waiting; r3=0xFFFF_FF80 one cycle after rvalid. With `WB_SUBWORD_EN` off, r3=0x0080_0000.
- Unsigned half load: addr[1:0]=2, `mem_rdata`=0xBEEF_0001 -> 0x0000_BEEF.
- Flush mid-load: accept load, assert `flush` in WAIT_MEM, then `mem_rvalid` 2 cycles later -> no write, state IDLE, `err_unexp`=0. A second `mem_rvalid` sets `err_unexp`=1.
- Back-to-back ALU ops: 3 ALU ops on consecutive cycles (r1,r2,r3) -> `regWriteFlag` high for 3 consecutive cycles with matching addr/data.
- Async reset mid-load: assert `rst` between clocks while in WAIT_MEM -> all outputs 0 immediately; `in_ready`=1 on the first cycle after release.
